// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the block-RAM FIFO: RAM aspect-ratio codes,
// depth limits per width and the data-bit to RAM-lane mapping.
package bram_fifo_pkg;

    typedef enum logic [2:0] {
        MODE_W36 = 3'b011,
        MODE_W18 = 3'b010,
        MODE_W9  = 3'b001,
        MODE_W4  = 3'b100,
        MODE_W2  = 3'b110,
        MODE_W1  = 3'b101
    } ram_mode_e;

    function automatic ram_mode_e mode_of(input int unsigned width);
        if (width <= 1)       return MODE_W1;
        else if (width <= 2)  return MODE_W2;
        else if (width <= 4)  return MODE_W4;
        else if (width <= 9)  return MODE_W9;
        else if (width <= 18) return MODE_W18;
        else                  return MODE_W36;
    endfunction

    function automatic int unsigned max_depth_log2(input int unsigned width);
        case (mode_of(width))
            MODE_W1:  return 15;
            MODE_W2:  return 14;
            MODE_W4:  return 13;
            MODE_W9:  return 12;
            MODE_W18: return 11;
            default:  return 10;
        endcase
    endfunction

    function automatic bit width_legal(input int unsigned width);
        return width inside {1, 2, 4, 8, 9, 16, 18, 32, 36};
    endfunction

    function automatic bit has_parity(input int unsigned width);
        return width inside {9, 18, 36};
    endfunction

    function automatic bit is_narrow(input int unsigned width);
        return mode_of(width) inside {MODE_W1, MODE_W2, MODE_W4};
    endfunction

    // Physical RAM word: narrow modes are used as-is, byte modes occupy whole 18-bit lanes
    function automatic int unsigned ram_width(input int unsigned width);
        if (is_narrow(width)) return width;
        return 18 * ((width + 17) / 18);
    endfunction

    // Each 18-bit lane holds two bytes in [15:0] and their parity bits in [17:16]
    function automatic int unsigned ram_bit(input int unsigned width, input int unsigned i);
        int unsigned lane_bits;
        int unsigned byte_idx;
        int unsigned bit_idx;
        if (is_narrow(width)) return i;
        lane_bits = has_parity(width) ? 9 : 8;
        byte_idx  = i / lane_bits;
        bit_idx   = i % lane_bits;
        if (bit_idx == 8) return 18 * (byte_idx / 2) + 16 + (byte_idx % 2);
        return 18 * (byte_idx / 2) + 8 * (byte_idx % 2) + bit_idx;
    endfunction

endpackage

// File: rtl/bram_fifo_mem.sv
// Simple-dual-port memory with registered, enable-gated read port.
// Maps the user word onto the RAM data/parity lanes of the chosen aspect ratio.
module bram_fifo_mem
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned RAM_W = ram_width(DATA_WIDTH);

    logic [RAM_W-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [RAM_W-1:0] wword;
    logic [RAM_W-1:0] rword;

    // Scatter the write word onto RAM lanes; unused lane bits are written 0
    always_comb begin
        wword = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            wword[ram_bit(DATA_WIDTH, i)] = wdata[i];
        end
    end

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wword;
    end

    // Read port: output register holds its value between reads
    always_ff @(posedge clk) begin
        if (re) rword <= mem[raddr];
    end

    // Gather the read word back from the RAM lanes
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            rdata[i] = rword[ram_bit(DATA_WIDTH, i)];
        end
    end

endmodule

// File: rtl/bram_sync_fifo.sv
// Synchronous FIFO on a single block RAM: pointers, occupancy, flags,
// sticky error bits and the optional first-word-fall-through output stage.
module bram_sync_fifo
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 18,
    parameter int unsigned DEPTH_LOG2    = 10,
    parameter bit          FWFT          = 1'b1,
    parameter int unsigned AFULL_THRESH  = 2**DEPTH_LOG2 - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  FLUSH_i,
    input  logic                  WEN_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    output logic                  FULL_o,
    output logic                  AFULL_o,
    input  logic                  REN_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    output logic                  RVALID_o,
    output logic                  EMPTY_o,
    output logic                  AEMPTY_o,
    output logic [DEPTH_LOG2:0]   COUNT_o,
    output logic                  OVERFLOW_o,
    output logic                  UNDERFLOW_o
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);

    if (!width_legal(DATA_WIDTH)) begin : g_bad_width
        $error("bram_sync_fifo: DATA_WIDTH %0d not supported", DATA_WIDTH);
    end
    if (DEPTH_LOG2 > max_depth_log2(DATA_WIDTH)) begin : g_bad_depth
        $error("bram_sync_fifo: DEPTH_LOG2 %0d exceeds one 36K block at width %0d",
               DEPTH_LOG2, DATA_WIDTH);
    end

    ptr_t wr_ptr_q, rd_ptr_q;
    cnt_t count_q, count_next, mem_occ;
    logic ov_q, ov_next;
    logic rvalid_q, full_q, afull_q, empty_q, aempty_q;
    logic overflow_q, underflow_q;
    logic push, pop, issue;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Accept/issue decisions and next occupancy
    always_comb begin
        push       = WEN_i && !full_q && !FLUSH_i && !RST_i;
        pop        = REN_i && !empty_q && !FLUSH_i && !RST_i;
        mem_occ    = count_q - cnt_t'(ov_q);
        count_next = count_q + cnt_t'(push) - cnt_t'(pop);
        if (FWFT) begin
            // Refill the output stage whenever it is empty or being consumed
            issue = (mem_occ != '0) && (!ov_q || pop) && !FLUSH_i && !RST_i;
        end else begin
            issue = pop;
        end
        ov_next = issue ? 1'b1 : (pop ? 1'b0 : ov_q);
    end

    // Pointers, occupancy, output-stage flag and registered status flags
    always_ff @(posedge CLK_i) begin
        if (RST_i || FLUSH_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
            rvalid_q <= 1'b0;
            full_q   <= 1'b0;
            afull_q  <= (AFULL_THRESH == 0);
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (issue) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q  <= count_next;
            ov_q     <= FWFT ? ov_next : 1'b0;
            rvalid_q <= FWFT ? ov_next : pop;
            full_q   <= (count_next == cnt_t'(DEPTH));
            afull_q  <= (32'(count_next) >= AFULL_THRESH);
            aempty_q <= (32'(count_next) <= AEMPTY_THRESH);
            empty_q  <= FWFT ? !ov_next : (count_next == '0);
        end
    end

    // Sticky error flags: survive flush, cleared only by reset
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!FLUSH_i) begin
            if (WEN_i && full_q)  overflow_q  <= 1'b1;
            if (REN_i && empty_q) underflow_q <= 1'b1;
        end
    end

    bram_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .clk   (CLK_i),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (WDATA_i),
        .re    (issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Output drive; read data is suppressed while not valid
    always_comb begin
        RDATA_o     = rvalid_q ? ram_rdata : '0;
        RVALID_o    = rvalid_q;
        FULL_o      = full_q;
        AFULL_o     = afull_q;
        EMPTY_o     = empty_q;
        AEMPTY_o    = aempty_q;
        COUNT_o     = count_q;
        OVERFLOW_o  = overflow_q;
        UNDERFLOW_o = underflow_q;
    end

endmodule

// File: doc/bram_sync_fifo.md
# bram_sync_fifo

Parametrised synchronous FIFO built on one simple-dual-port block RAM (one TDP36K in SDP configuration), the next step up from the fixed 2x18 RAM wrappers. Width selects the RAM aspect ratio (1/2/4/9/18/36), depth is configurable up to the capacity of one 36K block, and two read styles are offered: standard (1-cycle read latency) and first-word-fall-through. Adds occupancy count, programmable almost-full/almost-empty, synchronous flush and sticky error flags. Sits between fabric producers/consumers and the RAM macro.

## Interface
- DATA_WIDTH, 18: word width; legal 1, 2, 4, 8, 9, 16, 18, 32, 36.
- DEPTH_LOG2, 10: FIFO depth = 2**DEPTH_LOG2; max 15/14/13/12/11/10 for width 1/2/4/≤9/≤18/≤36; elaboration error if exceeded.
- FWFT, 1: 1 = first-word-fall-through, 0 = standard read.
- AFULL_THRESH, 2**DEPTH_LOG2-4: AFULL_o when COUNT_o >= value.
- AEMPTY_THRESH, 4: AEMPTY_o when COUNT_o <= value.

- CLK_i  in  1  sole clock, rising edge.
- RST_i  in  1  synchronous, active-high reset.
- FLUSH_i  in  1  synchronous clear of FIFO contents.
- WEN_i  in  1  push request.
- WDATA_i  in  DATA_WIDTH  push data.
- FULL_o  out  1  COUNT_o == depth.
- AFULL_o  out  1  almost full.
- REN_i  in  1  pop request.
- RDATA_o  out  DATA_WIDTH  read data.
- RVALID_o  out  1  standard mode: RDATA_o valid this cycle; FWFT: equals !EMPTY_o.
- EMPTY_o  out  1  no word available to pop.
- AEMPTY_o  out  1  almost empty.
- COUNT_o  out  DEPTH_LOG2+1  words pushed and not yet popped.
- OVERFLOW_o  out  1  sticky: push attempted while full.
- UNDERFLOW_o  out  1  sticky: pop attempted while empty.

## Operation
- Pointers wr_ptr/rd_ptr, DEPTH_LOG2 bits, wrap modulo depth; count register DEPTH_LOG2+1 bits.
- Push accepted iff WEN_i && !FULL_o; WEN_i while full is dropped (even with a concurrent pop), sets OVERFLOW_o.
- Pop accepted iff REN_i && !EMPTY_o; REN_i while empty is ignored, sets UNDERFLOW_o.
- Simultaneous accepted push and pop: count unchanged.
- Standard mode: EMPTY_o = (count == 0); accepted pop issues a RAM read at rd_ptr; RDATA_o/RVALID_o next cycle; RAM output register holds between reads.
- FWFT mode: output stage is the RAM read register with flag ov. RAM read issued when mem_occ > 0 && (!ov || accepted pop); mem_occ = count - ov. Next ov = issue ? 1 : (pop ? 0 : ov). EMPTY_o = !ov. Capacity exactly depth (count includes the word in the output stage).
- RDATA_o forced to 0 whenever RVALID_o = 0.
- FLUSH_i: wr_ptr, rd_ptr, count, ov, RVALID_o cleared; overrides same-cycle WEN_i/REN_i (neither accepted, no error flags set); RAM contents and sticky flags untouched.
- RST_i: as FLUSH_i plus OVERFLOW_o/UNDERFLOW_o cleared; RST_i has priority over FLUSH_i.
- Reset values: FULL_o 0, AFULL_o 0 (unless AFULL_THRESH = 0), EMPTY_o 1, AEMPTY_o 1, COUNT_o 0, RVALID_o 0, RDATA_o 0, OVERFLOW_o 0, UNDERFLOW_o 0.
- Width 9/18/36: parity bits mapped to the RAM parity lanes (bit 8 → RAM bit 16 per 18-bit lane); 8/16/32 leave parity lanes written 0.

## Timing
- All flags and COUNT_o registered; they update the cycle after the accepted push/pop.
- Standard read latency: 1 cycle from accepted REN_i to RVALID_o.
- FWFT first-word latency: push at cycle T → EMPTY_o low at T+2.
- Sustained throughput 1 push + 1 pop per cycle in both modes, no bubbles while mem_occ > 0.
- No read of an address in the cycle it is written (RAM read-during-write behaviour never relied on).
- Flush/reset at cycle T: all state cleared at edge ending T; a push at T+1 is accepted.

## Structure
- Package bram_fifo_pkg: RAM mode codes (36→3'b011, 18→3'b010, 9→3'b001, 4→3'b100, 2→3'b110, 1→3'b101), function max_depth_log2(width), function mode_of(width).
- Sub-module bram_fifo_mem: simple-dual-port, sync-read, read-enable-gated memory with width-to-lane (parity) mapping, inferable onto TDP36K SDP.
- Top: pointers, count, flags, FWFT output control.

## Test plan
- DATA_WIDTH 18, DEPTH_LOG2 4, FWFT 0: push 16 words 0x00001..0x00010 → FULL_o 1, COUNT_o 16, AFULL_o high from count 12; 17th push → OVERFLOW_o 1, COUNT_o stays 16.
- Same config: pop 16 → RDATA_o 0x00001..0x00010 one cycle after each REN_i, then EMPTY_o 1; extra pop → UNDERFLOW_o 1, RVALID_o 0, RDATA_o 0.
- FWFT 1, width 9: push 0x1A5 at T → EMPTY_o low at T+2 with RDATA_o 0x1A5 (parity bit preserved); pop → EMPTY_o 1 next cycle.
- FWFT 1, depth 16: fill to 8, then push+pop every cycle for 100 cycles with incrementing data → COUNT_o stays 8, output sequence in order, no gaps.
- Wrap: 40 push/pop cycles at depth 16, pointers wrap twice → data integrity, COUNT_o correct at wrap.
- Count 10, FLUSH_i with concurrent WEN_i and REN_i → COUNT_o 0, EMPTY_o 1, sticky flags unchanged; RST_i then clears sticky flags.
